// File: rtl/ux607_i2c_master_xfer_seq_if.sv
// Request/response and byte-controller command bundle for the I2C transfer sequencer.
// master = sequencer side, slave = CSR front end plus byte controller side.
interface ux607_i2c_master_xfer_seq_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_rd;
    logic [6:0]  req_dev;
    logic [7:0]  req_reg;
    logic [1:0]  req_len;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_err;
    logic        rsp_al;
    logic        rsp_to;
    logic [31:0] rsp_rdata;
    logic        bc_start;
    logic        bc_stop;
    logic        bc_read;
    logic        bc_write;
    logic        bc_ack_in;
    logic [7:0]  bc_din;
    logic        bc_rst;
    logic        bc_cmd_ack;
    logic        bc_ack_out;
    logic [7:0]  bc_dout;
    logic        bc_al;

    modport master (
        input  req_valid, req_rd, req_dev, req_reg, req_len, req_wdata,
        input  bc_cmd_ack, bc_ack_out, bc_dout, bc_al,
        output req_ready, rsp_valid, rsp_err, rsp_al, rsp_to, rsp_rdata,
        output bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din, bc_rst
    );

    modport slave (
        output req_valid, req_rd, req_dev, req_reg, req_len, req_wdata,
        output bc_cmd_ack, bc_ack_out, bc_dout, bc_al,
        input  req_ready, rsp_valid, rsp_err, rsp_al, rsp_to, rsp_rdata,
        input  bc_start, bc_stop, bc_read, bc_write, bc_ack_in, bc_din, bc_rst
    );
endinterface

// File: rtl/ux607_i2c_master_xfer_seq.sv
// I2C register-transaction sequencer: START+dev, reg, optional repeated START, 1-4 data bytes, STOP; one response pulse.
// Latency: first command 1 cycle after acceptance, each next command 1 cycle after bc_cmd_ack; rsp 1 cycle after the last ack.
// Backpressure: req_ready only in IDLE; commands held until bc_cmd_ack. Optional watchdog under `I2C_XFER_SEQ_TIMEOUT_EN.
module ux607_i2c_master_xfer_seq #(
    parameter logic [15:0] TIMEOUT_CYC = 16'd50000
) (
    input logic clk,
    input logic nReset,
    ux607_i2c_master_xfer_seq_if.master bus
);
    typedef enum logic [2:0] {IDLE, DEV_W, REG, RS_DEV_R, WDATA, RDATA, STOP, RESP} state_t;

    typedef struct packed {
        logic       start;
        logic       stop;
        logic       read;
        logic       write;
        logic       ack_in;
        logic [7:0] din;
    } cmd_t;

    function automatic cmd_t mk_cmd(input logic start, input logic stop, input logic read,
                                    input logic write, input logic ack_in, input logic [7:0] din);
        return {start, stop, read, write, ack_in, din};
    endfunction

    state_t      state_q, state_d;
    cmd_t        cmd_q, cmd_d;
    logic [1:0]  cnt_q, cnt_d, cnt_nx;
    logic        rd_q, rd_d;
    logic [6:0]  dev_q, dev_d;
    logic [7:0]  regad_q, regad_d;
    logic [1:0]  len_q, len_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        al_q, al_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic        req_ready_q, req_ready_d;
    logic        last;
`ifdef I2C_XFER_SEQ_TIMEOUT_EN
    logic        to_q, to_d;
    logic        bc_rst_q, bc_rst_d;
    logic [15:0] wdog_q, wdog_d;
`endif

    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        cnt_d    = cnt_q;
        rd_d     = rd_q;
        dev_d    = dev_q;
        regad_d  = regad_q;
        len_d    = len_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        al_d     = al_q;
`ifdef I2C_XFER_SEQ_TIMEOUT_EN
        to_d     = to_q;
        bc_rst_d = 1'b0;
        wdog_d   = '0;
`endif
        last   = (cnt_q == len_q);
        cnt_nx = cnt_q + 2'd1;

        case (state_q)
            IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    rd_d    = bus.req_rd;
                    dev_d   = bus.req_dev;
                    regad_d = bus.req_reg;
                    len_d   = bus.req_len;
                    wdata_d = bus.req_wdata;
                    rdata_d = '0;
                    cnt_d   = '0;
                    err_d   = 1'b0;
                    al_d    = 1'b0;
`ifdef I2C_XFER_SEQ_TIMEOUT_EN
                    to_d    = 1'b0;
`endif
                    state_d = DEV_W;
                    cmd_d   = mk_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {bus.req_dev, 1'b0});
                end
            end
            RESP: state_d = IDLE;
            default: begin
                // Arbitration loss wins over a coincident ack: the bus is no longer ours.
                if (bus.bc_al) begin
                    al_d    = 1'b1;
                    state_d = RESP;
                end else if (bus.bc_cmd_ack) begin
                    case (state_q)
                        DEV_W: begin
                            if (bus.bc_ack_out) state_d = STOP;
                            else begin
                                state_d = REG;
                                cmd_d   = mk_cmd(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, regad_q);
                            end
                        end
                        REG: begin
                            if (bus.bc_ack_out) state_d = STOP;
                            else if (rd_q) begin
                                state_d = RS_DEV_R;
                                cmd_d   = mk_cmd(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, {dev_q, 1'b1});
                            end else begin
                                state_d = WDATA;
                                cnt_d   = '0;
                                cmd_d   = mk_cmd(1'b0, len_q == 2'd0, 1'b0, 1'b1, 1'b0, wdata_q[7:0]);
                            end
                        end
                        RS_DEV_R: begin
                            if (bus.bc_ack_out) state_d = STOP;
                            else begin
                                state_d = RDATA;
                                cnt_d   = '0;
                                cmd_d   = mk_cmd(1'b0, len_q == 2'd0, 1'b1, 1'b0, len_q == 2'd0, 8'h00);
                            end
                        end
                        WDATA: begin
                            // A NACK on the last byte already carried STOP with it.
                            if (bus.bc_ack_out) begin
                                if (last) begin
                                    err_d   = 1'b1;
                                    state_d = RESP;
                                end else state_d = STOP;
                            end else if (last) state_d = RESP;
                            else begin
                                cnt_d = cnt_nx;
                                cmd_d = mk_cmd(1'b0, cnt_nx == len_q, 1'b0, 1'b1, 1'b0,
                                               wdata_q[{cnt_nx, 3'b000} +: 8]);
                            end
                        end
                        RDATA: begin
                            rdata_d[{cnt_q, 3'b000} +: 8] = bus.bc_dout;
                            if (last) state_d = RESP;
                            else begin
                                cnt_d = cnt_nx;
                                cmd_d = mk_cmd(1'b0, cnt_nx == len_q, 1'b1, 1'b0, cnt_nx == len_q, 8'h00);
                            end
                        end
                        STOP: begin
                            err_d   = 1'b1;
                            state_d = RESP;
                        end
                        default: state_d = IDLE;
                    endcase
                end
`ifdef I2C_XFER_SEQ_TIMEOUT_EN
                else if (wdog_q == TIMEOUT_CYC - 16'd1) begin
                    to_d     = 1'b1;
                    bc_rst_d = 1'b1;
                    state_d  = RESP;
                end else wdog_d = wdog_q + 16'd1;
`endif
            end
        endcase

        if (state_d == STOP && state_q != STOP) cmd_d = mk_cmd(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
        if (state_d == RESP || state_d == IDLE) cmd_d = '0;
        rsp_valid_d = (state_d == RESP);
        req_ready_d = (state_d == IDLE);
    end

    always_ff @(posedge clk) begin
        if (!nReset) begin
            state_q     <= IDLE;
            cmd_q       <= '0;
            cnt_q       <= '0;
            rd_q        <= 1'b0;
            dev_q       <= '0;
            regad_q     <= '0;
            len_q       <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            al_q        <= 1'b0;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            dev_q       <= dev_d;
            regad_q     <= regad_d;
            len_q       <= len_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            al_q        <= al_d;
            rsp_valid_q <= rsp_valid_d;
            req_ready_q <= req_ready_d;
        end
    end

`ifdef I2C_XFER_SEQ_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (!nReset) begin
            to_q     <= 1'b0;
            bc_rst_q <= 1'b0;
            wdog_q   <= '0;
        end else begin
            to_q     <= to_d;
            bc_rst_q <= bc_rst_d;
            wdog_q   <= wdog_d;
        end
    end

    assign bus.rsp_to = to_q;
    assign bus.bc_rst = bc_rst_q;
`else
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
    assign bus.rsp_to = 1'b0;
    assign bus.bc_rst = 1'b0;
`endif

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = err_q;
    assign bus.rsp_al    = al_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.bc_start  = cmd_q.start;
    assign bus.bc_stop   = cmd_q.stop;
    assign bus.bc_read   = cmd_q.read;
    assign bus.bc_write  = cmd_q.write;
    assign bus.bc_ack_in = cmd_q.ack_in;
    assign bus.bc_din    = cmd_q.din;
endmodule

// File: tb/tb_ux607_i2c_master_xfer_seq.sv
// Bench for ux607_i2c_master_xfer_seq: byte-level transaction model, byte-controller responder, per-cycle compare.
module tb_ux607_i2c_master_xfer_seq;
    logic clk;
    logic nReset;
    ux607_i2c_master_xfer_seq_if bus();

    ux607_i2c_master_xfer_seq dut (.clk(clk), .nReset(nReset), .bus(bus));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rd;
        bit [6:0]   dev;
        bit [7:0]   rg;
        bit [1:0]   len;
        bit [31:0]  wdata;
        int         nack_at;
        int         al_at;
        bit [31:0]  rbytes;
        int         dly;
    } xfer_t;

    int n_chk = 0;
    int n_err = 0;
    int done_cnt = 0;
    bit chk_en = 0;

    // Model output: command words {start,stop,read,write,ack_in,din[7:0]} and the response.
    logic [12:0] exp_cmd[$];
    logic        exp_err, exp_al;
    logic [31:0] exp_rdata;
    logic [12:0] log_cmd[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [12:0] mk(input bit st, input bit sp, input bit rd, input bit wr,
                                       input bit ai, input logic [7:0] d);
        return {st, sp, rd, wr, ai, d};
    endfunction

    function automatic xfer_t mkx(input bit rd, input bit [6:0] dev, input bit [7:0] rg, input bit [1:0] len,
                                  input bit [31:0] wdata, input int nack_at, input int al_at,
                                  input bit [31:0] rbytes, input int dly);
        xfer_t t;
        t.rd = rd; t.dev = dev; t.rg = rg; t.len = len; t.wdata = wdata;
        t.nack_at = nack_at; t.al_at = al_at; t.rbytes = rbytes; t.dly = dly;
        return t;
    endfunction

    // Byte list of the transfer, truncated at the first NACK / arbitration loss.
    task automatic build_model(input xfer_t t);
        logic [12:0] seq[$];
        int n_hdr;
        exp_cmd.delete();
        exp_err = 1'b0; exp_al = 1'b0; exp_rdata = '0;
        seq.push_back(mk(1, 0, 0, 1, 0, {t.dev, 1'b0}));
        seq.push_back(mk(0, 0, 0, 1, 0, t.rg));
        if (t.rd) seq.push_back(mk(1, 0, 0, 1, 0, {t.dev, 1'b1}));
        n_hdr = seq.size();
        for (int k = 0; k <= int'(t.len); k++) begin
            bit lst;
            lst = (k == int'(t.len));
            if (t.rd) seq.push_back(mk(0, lst, 1, 0, lst, 8'h00));
            else      seq.push_back(mk(0, lst, 0, 1, 0, t.wdata[8*k +: 8]));
        end
        for (int i = 0; i < seq.size(); i++) begin
            exp_cmd.push_back(seq[i]);
            if (i == t.al_at) begin
                exp_al = 1'b1;
                break;
            end
            if (t.rd && i >= n_hdr) exp_rdata[8*(i-n_hdr) +: 8] = t.rbytes[8*(i-n_hdr) +: 8];
            if (i == t.nack_at && !(t.rd && i >= n_hdr)) begin
                exp_err = 1'b1;
                if (!seq[i][11]) exp_cmd.push_back(mk(0, 1, 0, 0, 0, 8'h00));
                break;
            end
        end
    endtask

    bit busy = 0, rsp_due = 0, rdy_due = 0;
    int pos = 0;

    always @(negedge clk) begin
        logic [12:0] cur;
        cur = {bus.bc_start, bus.bc_stop, bus.bc_read, bus.bc_write, bus.bc_ack_in, bus.bc_din};
        if (!chk_en) begin
            busy = 0; rsp_due = 0; rdy_due = 0; pos = 0;
        end else begin
            if (rsp_due) begin
                chk("rsp_valid", bus.rsp_valid, 1);
                chk("rsp_err", bus.rsp_err, exp_err);
                chk("rsp_al", bus.rsp_al, exp_al);
                chk("rsp_to", bus.rsp_to, 0);
                chk("rsp_rdata", bus.rsp_rdata, exp_rdata);
                rsp_due = 0;
                rdy_due = 1;
            end else begin
                chk("rsp_valid_quiet", bus.rsp_valid, 0);
                if (rdy_due) begin
                    chk("req_ready_after_rsp", bus.req_ready, 1);
                    rdy_due = 0;
                    done_cnt++;
                end
            end
            if (busy) begin
                chk("req_ready_busy", bus.req_ready, 0);
                if (pos < exp_cmd.size()) chk("cmd", cur, exp_cmd[pos]);
                if (bus.bc_cmd_ack || bus.bc_al) begin
                    log_cmd.push_back(cur);
                    pos++;
                    if (pos >= exp_cmd.size()) begin
                        busy = 0;
                        rsp_due = 1;
                    end
                end
            end else begin
                chk("cmd_idle", cur, 0);
            end
            if (bus.req_valid && bus.req_ready) begin
                busy = 1;
                pos = 0;
                log_cmd.delete();
            end
        end
    end

    task automatic run_xfer(input xfer_t t, input bit abort_in_read);
        int ri, rk, wait_c, start_done;
        build_model(t);
        start_done = done_cnt;
        @(posedge clk); #1;
        bus.req_valid = 1'b1;
        bus.req_rd = t.rd; bus.req_dev = t.dev; bus.req_reg = t.rg;
        bus.req_len = t.len; bus.req_wdata = t.wdata;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        ri = 0; rk = 0; wait_c = 0;
        for (int budget = 0; budget < 400 && done_cnt == start_done; budget++) begin
            bus.bc_cmd_ack = 1'b0; bus.bc_al = 1'b0; bus.bc_ack_out = 1'b0; bus.bc_dout = 8'h00;
            if (bus.bc_start || bus.bc_stop || bus.bc_read || bus.bc_write) begin
                if (abort_in_read && bus.bc_read && rk == 1) return;
                if (wait_c >= t.dly) begin
                    bus.bc_cmd_ack = 1'b1;
                    bus.bc_ack_out = (ri == t.nack_at);
                    bus.bc_al = (ri == t.al_at);
                    if (bus.bc_read) begin
                        bus.bc_dout = t.rbytes[8*rk +: 8];
                        rk++;
                    end
                    ri++;
                    wait_c = 0;
                end else wait_c++;
            end
            @(posedge clk); #1;
        end
        bus.bc_cmd_ack = 1'b0; bus.bc_al = 1'b0;
        if (done_cnt == start_done) chk("xfer_budget_expired", 0, 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_cmd"}, {bus.bc_start, bus.bc_stop, bus.bc_read, bus.bc_write, bus.bc_ack_in, bus.bc_din}, 0);
        chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        chk({tag, "_bc_rst"}, bus.bc_rst, 0);
    endtask

    logic [7:0] t1_din [4];

    initial begin
        #200000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1, "time limit");
    end

    initial begin
        xfer_t t1;
        t1_din = '{8'hA0, 8'h10, 8'hEF, 8'hBE};
        nReset = 1'b0;
        bus.req_valid = 0; bus.req_rd = 0; bus.req_dev = 0; bus.req_reg = 0; bus.req_len = 0; bus.req_wdata = 0;
        bus.bc_cmd_ack = 0; bus.bc_ack_out = 0; bus.bc_dout = 0; bus.bc_al = 0;
        repeat (3) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        chk("reset_req_ready", bus.req_ready, 1);
        chk("reset_rsp_flags", {bus.rsp_err, bus.rsp_al, bus.rsp_to}, 0);
        chk("reset_rdata", bus.rsp_rdata, 0);
        nReset = 1'b1;
        chk_en = 1'b1;

        t1 = mkx(0, 7'h50, 8'h10, 2'd1, 32'h0000BEEF, -1, -1, 0, 0);
        run_xfer(t1, 0);
        chk("t1_ncmd", log_cmd.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("t1_din%0d", i), log_cmd[i][7:0], t1_din[i]);
        chk("t1_start_first", {log_cmd[0][12], log_cmd[1][12], log_cmd[2][12], log_cmd[3][12]}, 4'b1000);
        chk("t1_stop_last", {log_cmd[0][11], log_cmd[1][11], log_cmd[2][11], log_cmd[3][11]}, 4'b0001);
        chk("t1_err", bus.rsp_err, 0);

        run_xfer(mkx(1, 7'h50, 8'h20, 2'd1, 0, -1, -1, 32'h00002211, 1), 0);
        chk("t2_rdata", bus.rsp_rdata, 32'h00002211);
        chk("t2_rs_addr", log_cmd[2], 13'h1000 | 13'h0200 | 13'h00A1);
        chk("t2_ack_in", {log_cmd[3][8], log_cmd[4][8]}, 2'b01);
        chk("t2_stop", {log_cmd[3][11], log_cmd[4][11]}, 2'b01);

        run_xfer(mkx(0, 7'h50, 8'h30, 2'd3, 32'h44332211, 1, -1, 0, 2), 0);
        chk("t3_ncmd", log_cmd.size(), 3);
        chk("t3_stop_only", log_cmd[2], 13'h0800);
        chk("t3_err", bus.rsp_err, 1);

        run_xfer(mkx(0, 7'h3A, 8'h40, 2'd2, 32'h00CCBBAA, -1, 3, 0, 1), 0);
        chk("t4_ncmd", log_cmd.size(), 4);
        chk("t4_flags", {bus.rsp_al, bus.rsp_err}, 2'b10);

        run_xfer(mkx(1, 7'h50, 8'h21, 2'd3, 0, -1, -1, 32'hDDCCBBAA, 0), 0);
        chk("t5_rdata", bus.rsp_rdata, 32'hDDCCBBAA);
        run_xfer(mkx(1, 7'h50, 8'h22, 2'd1, 0, 2, -1, 32'h00009988, 0), 0);
        chk("t6_rdata_clear", bus.rsp_rdata, 0);
        run_xfer(mkx(0, 7'h12, 8'h33, 2'd0, 32'h0000005A, 2, -1, 0, 1), 0);
        chk("t7_ncmd", log_cmd.size(), 3);

        run_xfer(mkx(1, 7'h50, 8'h23, 2'd3, 0, -1, -1, 32'h44332211, 0), 1);
        chk("t8_in_rdata", bus.bc_read, 1);
        chk_en = 1'b0;
        nReset = 1'b0;
        @(posedge clk); #1;
        check_idle_outputs("midreset");
        nReset = 1'b1;
        @(posedge clk); #1;
        chk("midreset_req_ready", bus.req_ready, 1);
        chk_en = 1'b1;
        run_xfer(t1, 0);
        chk("t9_ncmd", log_cmd.size(), 4);
        chk("t9_last_din", log_cmd[3][7:0], 8'hBE);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
